line_fetcher: RTL

Fetches one scan line of 12-bit RGB444 pixels from the external framebuffer memory into a double-buffered (ping-pong) line RAM, one line ahead of the display. It sits directly upstream of the VGA timing generator. The timing generator signals line and frame boundaries and reads pixels by column index. All memory traffic runs in one clock domain through an in-order request/response handshake.

---
 rtl/line_fetcher.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/line_fetcher.sv
// Purpose: prefetch one RGB444 scan line from framebuffer memory into a ping-pong line RAM, one line ahead of display.
// Latency: pixel_data is registered one cycle after pixel_index; mem_read is asserted in the cycle after a fetch-starting pulse.
// Backpressure: requests hold address until mem_ready; issue stops at MAX_OUTSTANDING in flight or while enable is low.
// Optional feature macro: LINE_FETCHER_STATS_EN adds a 16-bit saturating underrun_count output.
module line_fetcher #(
  parameter int LINE_WIDTH      = 640,
  parameter int FRAME_LINES     = 480,
  parameter int ADDRESS_WIDTH   = 22,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic                     line_start,
  input  logic [9:0]               pixel_index,
  output logic [11:0]              pixel_data,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read,
  input  logic                     mem_ready,
  input  logic                     mem_valid,
  input  logic [11:0]              mem_data,
  output logic                     line_ready,
  output logic                     underrun
`ifdef LINE_FETCHER_STATS_EN
  ,
  output logic [15:0]              underrun_count
`endif
);

  localparam logic [10:0] LINE_COUNT_MAX = 11'(LINE_WIDTH);
  localparam logic [10:0] LAST_LINE_END  = 11'(FRAME_LINES);
  localparam logic [2:0]  OUT_LIMIT      = 3'(MAX_OUTSTANDING);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_STRIDE = ADDRESS_WIDTH'(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                   state;
  logic [10:0]              fetch_line;
  logic [10:0]              issue_count;
  logic [10:0]              write_count;
  logic [2:0]               outstanding;
  logic [2:0]               outstanding_next;
  logic [ADDRESS_WIDTH-1:0] line_base;
  logic                     disp_bank;
  logic                     disp_valid;

  logic                     accept;
  logic                     resp_take;
  logic                     write_en;
  logic [10:0]              next_line;
  logic [ADDRESS_WIDTH-1:0] next_base;

  logic [11:0] bank0 [LINE_WIDTH];
  logic [11:0] bank1 [LINE_WIDTH];

  // Request valid follows enable in the same cycle so a paused fetch never leaves a stale request up.
  assign mem_read = (state == FETCH) && enable && (outstanding < OUT_LIMIT) && (issue_count < LINE_COUNT_MAX);

  // Handshake bookkeeping shared by the FSM and the bank write port.
  always_comb begin
    accept           = mem_read && mem_ready;
    resp_take        = mem_valid && (outstanding != 3'd0);
    write_en         = resp_take && ((state == FETCH) || (state == DRAIN)) && (write_count < LINE_COUNT_MAX);
    next_line        = fetch_line + 11'd1;
    next_base        = line_base + LINE_STRIDE;
    outstanding_next = outstanding;
    unique case ({accept, resp_take})
      2'b10:   outstanding_next = outstanding + 3'd1;
      2'b01:   outstanding_next = outstanding - 3'd1;
      default: outstanding_next = outstanding;
    endcase
  end

  // Fetch FSM: issue, drain, flush after abort, and line/frame boundary handling (frame_start wins).
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_line  <= '0;
      issue_count <= '0;
      write_count <= '0;
      outstanding <= '0;
      line_base   <= '0;
      mem_address <= '0;
      disp_bank   <= 1'b0;
      disp_valid  <= 1'b0;
      line_ready  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      underrun    <= 1'b0;
      if (accept) begin
        issue_count <= issue_count + 11'd1;
        mem_address <= mem_address + 1'b1;
      end
      if (write_en) begin
        write_count <= write_count + 11'd1;
      end

      unique case (state)
        FETCH: if (accept && (issue_count + 11'd1 == LINE_COUNT_MAX)) state <= DRAIN;
        DRAIN: if (write_en && (write_count + 11'd1 == LINE_COUNT_MAX)) begin
          state      <= IDLE;
          line_ready <= 1'b1;
        end
        FLUSH: if (outstanding_next == 3'd0) state <= (fetch_line < LAST_LINE_END) ? FETCH : IDLE;
        default: ;
      endcase

      if (frame_start) begin
        fetch_line  <= '0;
        disp_valid  <= 1'b0;
        line_ready  <= 1'b0;
        line_base   <= '0;
        mem_address <= '0;
        issue_count <= '0;
        write_count <= '0;
        state       <= (outstanding_next != 3'd0) ? FLUSH : FETCH;
      end else if (line_start) begin
        if (fetch_line >= LAST_LINE_END) begin
          // Past the last visible line: nothing to show or fetch until the next frame.
          disp_valid <= 1'b0;
        end else begin
          if (line_ready) begin
            disp_bank  <= ~disp_bank;
            disp_valid <= 1'b1;
            line_ready <= 1'b0;
          end else begin
            // Fill bank is incomplete: blank the display and abandon the partial line.
            underrun   <= 1'b1;
            disp_valid <= 1'b0;
          end
          fetch_line  <= next_line;
          line_base   <= next_base;
          mem_address <= next_base;
          issue_count <= '0;
          write_count <= '0;
          if (outstanding_next != 3'd0) state <= FLUSH;
          else state <= (next_line < LAST_LINE_END) ? FETCH : IDLE;
        end
      end
    end
  end

  // Response write port: always targets the bank not being displayed.
  always_ff @(posedge clock) begin
    if (write_en && disp_bank)  bank0[write_count[9:0]] <= mem_data;
    if (write_en && !disp_bank) bank1[write_count[9:0]] <= mem_data;
  end

  // Display read port: blank when no valid line is shown or the column is off the end.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_data <= '0;
    end else if (disp_valid && ({1'b0, pixel_index} < LINE_COUNT_MAX)) begin
      pixel_data <= disp_bank ? bank1[pixel_index] : bank0[pixel_index];
    end else begin
      pixel_data <= '0;
    end
  end

`ifdef LINE_FETCHER_STATS_EN
  // Saturating count of underrun pulses, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
